// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin share of one registered ALU among NUM_REQ valid/ready requesters; ports: req_* in, rsp_* tagged response out, alu_* to/from ALU, busy
module alu_rr_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int OPCODE_WIDTH = 3,
  parameter int ID_WIDTH     = 2
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*OPCODE_WIDTH-1:0] req_opcode,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_op1,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_op2,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [ID_WIDTH-1:0]            rsp_id,
  output logic [DATA_WIDTH-1:0]          rsp_result,
  output logic                           rsp_carry,
  output logic                           rsp_zero,
  output logic                           busy,
  output logic [OPCODE_WIDTH-1:0]        alu_opcode,
  output logic [DATA_WIDTH-1:0]          alu_op1,
  output logic [DATA_WIDTH-1:0]          alu_op2,
  input  logic [DATA_WIDTH-1:0]          alu_result,
  input  logic                           alu_carry,
  input  logic                           alu_zero
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
  state_t state;
  logic [ID_WIDTH-1:0] last_grant, winner;
  always_comb begin
    logic [ID_WIDTH-1:0] idx;
    idx = '0;
    winner = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ID_WIDTH'((int'(last_grant) + k) % NUM_REQ);
      winner = req_valid[idx] ? idx : winner;
    end
  end
  assign req_ready = (rstn && state == IDLE && |req_valid) ? NUM_REQ'(1) << winner : '0;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      last_grant <= ID_WIDTH'(NUM_REQ - 1);
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      alu_opcode <= '0;
      alu_op1    <= '0;
      alu_op2    <= '0;
    end else begin
      case (state)
        IDLE: if (|req_valid) begin
          alu_opcode <= req_opcode[winner*OPCODE_WIDTH +: OPCODE_WIDTH];
          alu_op1    <= req_op1[winner*DATA_WIDTH +: DATA_WIDTH];
          alu_op2    <= req_op2[winner*DATA_WIDTH +: DATA_WIDTH];
          rsp_id     <= winner;
          last_grant <= winner;
          state      <= ISSUE;
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          rsp_result <= alu_result;
          rsp_carry  <= alu_carry;
          rsp_zero   <= alu_zero;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter: directed scoreboard bench for alu_rr_arbiter with a registered ALU model
module tb_alu_rr_arbiter;
  localparam int N = 4, DW = 32, OW = 3, IW = 2;
  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;
  logic [N-1:0] req_valid, req_ready, hold, rr;
  logic [N*OW-1:0] req_opcode;
  logic [N*DW-1:0] req_op1, req_op2;
  logic rsp_valid, rsp_ready, rsp_carry, rsp_zero, busy, alu_carry, alu_zero;
  logic [IW-1:0] rsp_id;
  logic [DW-1:0] rsp_result, alu_op1, alu_op2, alu_result;
  logic [OW-1:0] alu_opcode;
  logic [DW:0] alu_n;
  typedef struct packed {logic [IW-1:0] id; logic [DW-1:0] res; logic c; logic z;} exp_t;
  exp_t sbq[$];
  int glog[$], gcyc[$];
  int checks = 0, passed = 0, cyc = 0, last_gcyc = 0, nrsp = 0, gi = 0;
  logic was_v = 1'b0;
  logic [IW-1:0] last_id;
  logic [DW-1:0] last_res;
  logic last_c, last_z;

  alu_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .OPCODE_WIDTH(OW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_op1(req_op1), .req_op2(req_op2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .busy(busy),
    .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero)
  );

  function automatic logic [DW:0] alu_f(input logic [OW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      3'd0: alu_f = {1'b0, a} + {1'b0, b};
      3'd1: alu_f = {1'b0, a} - {1'b0, b};
      3'd2: alu_f = {1'b0, a} + (DW+1)'(1);
      3'd3: alu_f = {1'b0, a} - (DW+1)'(1);
      3'd4: alu_f = {1'b0, a & b};
      3'd5: alu_f = {1'b0, a | b};
      3'd6: alu_f = {1'b0, ~(a & b)};
      default: alu_f = {1'b0, a ^ b};
    endcase
  endfunction

  assign alu_n = alu_f(alu_opcode, alu_op1, alu_op2);
  always_ff @(posedge clk) begin
    {alu_carry, alu_result} <= alu_n;
    alu_zero <= alu_n[DW-1:0] == '0;
  end

  function automatic exp_t model(input int i);
    logic [DW:0] r;
    r = alu_f(req_opcode[i*OW +: OW], req_op1[i*DW +: DW], req_op2[i*DW +: DW]);
    model = '{id: IW'(i), res: r[DW-1:0], c: r[DW], z: (r[DW-1:0] == '0)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      sbq.delete();
      was_v = 1'b0;
    end else begin
      if (|req_ready) begin
        chk("grant_onehot", 128'($onehot(req_ready)), 1);
        for (int i = 0; i < N; i++) if (req_ready[i]) gi = i;
        glog.push_back(gi);
        gcyc.push_back(cyc);
        last_gcyc = cyc;
        sbq.push_back(model(gi));
      end
      if (rsp_valid && !was_v) chk("latency", 128'(cyc - last_gcyc), 3);
      was_v = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        chk("rsp_expected", 128'(sbq.size() > 0), 1);
        if (sbq.size() > 0) begin
          exp_t e;
          e = sbq.pop_front();
          chk("rsp_id", rsp_id, e.id);
          chk("rsp_result", rsp_result, e.res);
          chk("rsp_carry", rsp_carry, e.c);
          chk("rsp_zero", rsp_zero, e.z);
        end
        {last_id, last_res, last_c, last_z} = {rsp_id, rsp_result, rsp_carry, rsp_zero};
        nrsp++;
      end
    end
  end

  task automatic cycle();
    @(negedge clk);
    rr = req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (rr[i] && !hold[i]) req_valid[i] = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [OW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_opcode[i*OW +: OW] = op;
    req_op1[i*DW +: DW] = a;
    req_op2[i*DW +: DW] = b;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_grant(input int i, input int budget);
    int n = 0;
    do begin cycle(); n++; end while (!rr[i] && n < budget);
    chk("grant_wait", rr[i], 1);
  endtask

  task automatic wait_rsp(input int cnt, input int budget);
    int n = 0, target;
    target = nrsp + cnt;
    while (nrsp < target && n < budget) begin cycle(); n++; end
    chk("rsp_wait", 128'(nrsp >= target), 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp"}, {rsp_id, rsp_result, rsp_carry, rsp_zero}, 0);
    chk({tag, "_alu"}, {alu_opcode, alu_op1, alu_op2}, 0);
  endtask

  task automatic reset_dut(input string tag);
    req_valid = '0;
    rstn = 1'b0;
    #1;
    check_zero(tag);
    repeat (2) cycle();
    rstn = 1'b1;
  endtask

  initial begin
    int g0, n;
    req_valid = '0; hold = '0; rr = '0; rsp_ready = 1'b0;
    req_opcode = '0; req_op1 = '0; req_op2 = '0;
    reset_dut("reset");
    rsp_ready = 1'b1;
    set_req(0, 3'd0, 32'hFFFF_FFFF, 32'h1);
    wait_rsp(1, 20);
    chk("t1_id", last_id, 0);
    chk("t1_result", last_res, 32'h0);
    chk("t1_carry", last_c, 1);
    chk("t1_zero", last_z, 1);
    set_req(2, 3'd1, 32'd5, 32'd7);
    wait_grant(2, 10);
    chk("t2_issue_opcode", alu_opcode, 1);
    chk("t2_issue_ops", {alu_op1, alu_op2}, {32'd5, 32'd7});
    wait_rsp(1, 20);
    chk("t2_result", last_res, 32'hFFFF_FFFE);
    chk("t2_flags", {last_id, last_c, last_z}, {2'd2, 1'b1, 1'b0});
    set_req(3, 3'd3, 32'd1, 32'd0);
    wait_rsp(1, 20);
    chk("t6_result", last_res, 32'h0);
    chk("t6_flags", {last_id, last_c, last_z}, {2'd3, 1'b0, 1'b1});
    g0 = glog.size();
    set_req(0, 3'd0, 32'd1, 32'd2);
    set_req(3, 3'd7, 32'd3, 32'd3);
    wait_rsp(2, 30);
    if (glog.size() >= g0 + 2) begin
      chk("t6_first", glog[g0], 0);
      chk("t6_second", glog[g0+1], 3);
    end
    rsp_ready = 1'b0;
    set_req(1, 3'd7, 32'hA5A5_A5A5, 32'hFFFF_FFFF);
    wait_grant(1, 10);
    set_req(3, 3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00);
    n = 0;
    while (!rsp_valid && n < 10) begin cycle(); n++; end
    chk("t4_rsp_wait", rsp_valid, 1);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t4_hold_ready", rr, 0);
      chk("t4_hold_valid", rsp_valid, 1);
      chk("t4_hold_result", {rsp_id, rsp_result}, {2'd1, 32'h5A5A_5A5A});
    end
    rsp_ready = 1'b1;
    cycle();
    cycle();
    chk("t4_req3_next", rr, 4'b1000);
    wait_rsp(1, 20);
    set_req(2, 3'd0, 32'd3, 32'd4);
    wait_grant(2, 10);
    cycle();
    chk("t5_capture_busy", {busy, rsp_valid}, 2'b10);
    reset_dut("t5_abort");
    g0 = glog.size();
    set_req(0, 3'd5, 32'h00FF_0000, 32'h0000_00FF);
    set_req(1, 3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_rsp(2, 30);
    if (glog.size() >= g0 + 2) begin
      chk("t5_first", glog[g0], 0);
      chk("t5_second", glog[g0+1], 1);
    end
    reset_dut("t3_reset");
    hold = '1;
    set_req(0, 3'd2, 32'hFFFF_FFFF, 32'd0);
    set_req(1, 3'd4, 32'h1234_5678, 32'h0F0F_0F0F);
    set_req(2, 3'd1, 32'd9, 32'd9);
    set_req(3, 3'd0, 32'h8000_0000, 32'h7FFF_FFFF);
    g0 = glog.size();
    n = 0;
    while (glog.size() < g0 + 6 && n < 60) begin cycle(); n++; end
    hold = '0;
    req_valid = '0;
    chk("t3_grants", 128'(glog.size() >= g0 + 6), 1);
    n = 0;
    while (busy && n < 10) begin cycle(); n++; end
    for (int k = 0; k < 6; k++) if (glog.size() > g0 + k) chk("t3_order", glog[g0+k], k % 4);
    for (int k = 1; k < 6; k++) if (gcyc.size() > g0 + k) chk("t3_spacing", gcyc[g0+k] - gcyc[g0+k-1], 4);
    chk("sb_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
